// File: rtl/cpu_pipe_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pipe_pkg
// Shared types and constants for the CPU pipeline stages.
//   DEF_DW / DEF_RW : default data width and register-number width
//   wb_entry_t      : layout of one MEM/WB entry at the default widths
//   state_t         : skid-stage occupancy, encoded as {main.valid, skid.valid}
//   entry_width()   : flat bit width of an entry for arbitrary DW/RW
// ---------------------------------------------------------------------------
package cpu_pipe_pkg;

    localparam int DEF_DW = 32;
    localparam int DEF_RW = 5;

    // Field order matches the flat packing used by memwb_skid_stage.
    typedef struct packed {
        logic              wreg;
        logic              m2reg;
        logic [DEF_DW-1:0] alu;
        logic [DEF_DW-1:0] mo;
        logic [DEF_DW-1:0] wdata;
        logic [DEF_RW-1:0] rn;
    } wb_entry_t;

    // The encoding is the pair of valid bits itself, so the state costs no
    // extra flops.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_BUSY  = 2'b10,
        ST_FULL  = 2'b11
    } state_t;

    function automatic int entry_width(input int dw, input int rw);
        return 2 + 3 * dw + rw;
    endfunction

endpackage

// File: rtl/wb_entry_reg.sv
// ---------------------------------------------------------------------------
// wb_entry_reg
// One pipeline entry: a W-bit payload plus a valid bit.
//   clk, clrn : clock (rising edge), asynchronous active-low reset
//   load      : capture d and set valid (wins over clear)
//   clear     : drop valid; payload is kept as-is
//   d         : payload to capture
//   valid, q  : registered valid bit and payload (both 0 after reset)
// ---------------------------------------------------------------------------
module wb_entry_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clrn,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/memwb_skid_stage.sv
// ---------------------------------------------------------------------------
// memwb_skid_stage
// MEM/WB pipeline register with a valid/ready handshake and a 2-entry skid
// buffer, synchronous flush and write-back data pre-selection.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready is registered (no combinational path from out_ready), and
// in_valid/out_valid never depend on the same-cycle ready of their partner.
//
// Ports:
//   clk, clrn        : clock (rising edge), asynchronous active-low reset
//   flush            : synchronous; drops held entries and the current input
//   in_valid/in_ready: MEM-side handshake
//   in_wreg, in_m2reg, in_alu, in_mo, in_rn : MEM-side entry fields
//   out_valid/out_ready: WB-side handshake
//   out_wreg, out_m2reg, out_alu, out_mo, out_wdata, out_rn : WB-side entry
//   dbg_state        : current occupancy (cpu_pipe_pkg::state_t encoding)
//   fwd_hit, fwd_rn, fwd_data : ID-stage bypass, only when MEMWB_FWD_EN is
//                      defined
// ---------------------------------------------------------------------------
module memwb_skid_stage
    import cpu_pipe_pkg::*;
#(
    parameter int DW        = DEF_DW,
    parameter int RW        = DEF_RW,
    parameter bit ZERO_SKIP = 1'b1
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_wreg,
    input  logic          in_m2reg,
    input  logic [DW-1:0] in_alu,
    input  logic [DW-1:0] in_mo,
    input  logic [RW-1:0] in_rn,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_wreg,
    output logic          out_m2reg,
    output logic [DW-1:0] out_alu,
    output logic [DW-1:0] out_mo,
    output logic [DW-1:0] out_wdata,
    output logic [RW-1:0] out_rn,
    output logic [1:0]    dbg_state
`ifdef MEMWB_FWD_EN
    ,
    output logic          fwd_hit,
    output logic [RW-1:0] fwd_rn,
    output logic [DW-1:0] fwd_data
`endif
);

    localparam int EW = entry_width(DW, RW);

    logic [EW-1:0] in_pack;
    logic [EW-1:0] main_d;
    logic [EW-1:0] main_q;
    logic [EW-1:0] skid_q;
    logic          main_v;
    logic          skid_v;
    logic          main_load;
    logic          main_clear;
    logic          main_from_skid;
    logic          skid_load;
    logic          skid_clear;
    logic          main_wreg;
    logic          cap_wreg;
    logic [DW-1:0] cap_wdata;
    logic          rdy_q;
    logic          accept;
    logic          pop;
    state_t        state;
    state_t        next_state;

    // Capture-time decode: register-0 writes become bubbles-for-the-regfile,
    // and the write-back mux is resolved here so WB sees a single data bus.
    assign cap_wreg  = in_wreg & ~(ZERO_SKIP & (in_rn == '0));
    assign cap_wdata = in_m2reg ? in_mo : in_alu;
    assign in_pack   = {cap_wreg, in_m2reg, in_alu, in_mo, cap_wdata, in_rn};

    assign state  = state_t'({main_v, skid_v});
    assign accept = in_valid & rdy_q & ~flush;
    assign pop    = main_v & out_ready;

    always_comb begin
        next_state     = state;
        main_load      = 1'b0;
        main_clear     = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (accept) begin
                    main_load  = 1'b1;
                    next_state = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (accept && pop) begin
                    main_load  = 1'b1;
                end else if (accept) begin
                    skid_load  = 1'b1;
                    next_state = ST_FULL;
                end else if (pop) begin
                    main_clear = 1'b1;
                    next_state = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // in_ready is 0 here, so only the pop can move us.
                if (pop) begin
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                    skid_clear     = 1'b1;
                    next_state     = ST_BUSY;
                end
            end
            default: begin
                // Skid valid without main valid cannot arise; recover to empty.
                main_clear = 1'b1;
                skid_clear = 1'b1;
                next_state = ST_EMPTY;
            end
        endcase
        // Flush overrides everything: valid bits drop, payloads stay put.
        // A pop in the same cycle has already been seen by WB.
        if (flush) begin
            main_load  = 1'b0;
            skid_load  = 1'b0;
            main_clear = 1'b1;
            skid_clear = 1'b1;
            next_state = ST_EMPTY;
        end
    end

    assign main_d = main_from_skid ? skid_q : in_pack;

    // Ready is registered from the next state so WB stalls never reach MEM
    // combinationally; the skid entry absorbs the one beat in flight.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            rdy_q <= 1'b1;
        end else begin
            rdy_q <= (next_state != ST_FULL);
        end
    end

    wb_entry_reg #(.W(EW)) u_main (
        .clk   (clk),
        .clrn  (clrn),
        .load  (main_load),
        .clear (main_clear),
        .d     (main_d),
        .valid (main_v),
        .q     (main_q)
    );

    wb_entry_reg #(.W(EW)) u_skid (
        .clk   (clk),
        .clrn  (clrn),
        .load  (skid_load),
        .clear (skid_clear),
        .d     (in_pack),
        .valid (skid_v),
        .q     (skid_q)
    );

    assign {main_wreg, out_m2reg, out_alu, out_mo, out_wdata, out_rn} = main_q;

    assign in_ready  = rdy_q;
    assign out_valid = main_v;
    assign out_wreg  = main_wreg & main_v;
    assign dbg_state = state;

`ifdef MEMWB_FWD_EN
    assign fwd_hit  = main_v & main_wreg;
    assign fwd_rn   = out_rn;
    assign fwd_data = out_wdata;
`endif

endmodule

// File: tb/tb_memwb_skid_stage.sv
// ---------------------------------------------------------------------------
// tb_memwb_skid_stage
// Self-checking bench for memwb_skid_stage. A queue model tracks the entries
// the stage should hold; a negedge monitor compares the handshake and the
// head entry against it, and each scenario task adds its own targeted checks.
// A second instance with ZERO_SKIP=0 shares the inputs.
// ---------------------------------------------------------------------------
module tb_memwb_skid_stage;
    import cpu_pipe_pkg::*;

    localparam int DW = DEF_DW;
    localparam int RW = DEF_RW;
    localparam int EW = entry_width(DW, RW);

    logic          clk;
    logic          clrn;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic          in_wreg;
    logic          in_m2reg;
    logic [DW-1:0] in_alu;
    logic [DW-1:0] in_mo;
    logic [RW-1:0] in_rn;
    logic          out_valid;
    logic          out_ready;
    logic          out_wreg;
    logic          out_m2reg;
    logic [DW-1:0] out_alu;
    logic [DW-1:0] out_mo;
    logic [DW-1:0] out_wdata;
    logic [RW-1:0] out_rn;
    logic [1:0]    dbg_state;

    logic          nz_in_ready;
    logic          nz_out_valid;
    logic          nz_out_wreg;
    logic          nz_out_m2reg;
    logic [DW-1:0] nz_out_alu;
    logic [DW-1:0] nz_out_mo;
    logic [DW-1:0] nz_out_wdata;
    logic [RW-1:0] nz_out_rn;
    logic [1:0]    nz_dbg_state;

`ifdef MEMWB_FWD_EN
    logic          fwd_hit;
    logic [RW-1:0] fwd_rn;
    logic [DW-1:0] fwd_data;
    logic          nz_fwd_hit;
    logic [RW-1:0] nz_fwd_rn;
    logic [DW-1:0] nz_fwd_data;
`endif

    int n_cmp = 0;
    int n_err = 0;
    bit mon_en = 1'b0;

    // Scoreboard model state
    logic [EW-1:0] exp_q[$];
    bit            m_rdy = 1'b1;

    memwb_skid_stage #(.DW(DW), .RW(RW), .ZERO_SKIP(1'b1)) dut (
        .clk       (clk),
        .clrn      (clrn),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_wreg   (in_wreg),
        .in_m2reg  (in_m2reg),
        .in_alu    (in_alu),
        .in_mo     (in_mo),
        .in_rn     (in_rn),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_wreg  (out_wreg),
        .out_m2reg (out_m2reg),
        .out_alu   (out_alu),
        .out_mo    (out_mo),
        .out_wdata (out_wdata),
        .out_rn    (out_rn),
        .dbg_state (dbg_state)
`ifdef MEMWB_FWD_EN
        ,
        .fwd_hit   (fwd_hit),
        .fwd_rn    (fwd_rn),
        .fwd_data  (fwd_data)
`endif
    );

    memwb_skid_stage #(.DW(DW), .RW(RW), .ZERO_SKIP(1'b0)) dut_nz (
        .clk       (clk),
        .clrn      (clrn),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (nz_in_ready),
        .in_wreg   (in_wreg),
        .in_m2reg  (in_m2reg),
        .in_alu    (in_alu),
        .in_mo     (in_mo),
        .in_rn     (in_rn),
        .out_valid (nz_out_valid),
        .out_ready (out_ready),
        .out_wreg  (nz_out_wreg),
        .out_m2reg (nz_out_m2reg),
        .out_alu   (nz_out_alu),
        .out_mo    (nz_out_mo),
        .out_wdata (nz_out_wdata),
        .out_rn    (nz_out_rn),
        .dbg_state (nz_dbg_state)
`ifdef MEMWB_FWD_EN
        ,
        .fwd_hit   (nz_fwd_hit),
        .fwd_rn    (nz_fwd_rn),
        .fwd_data  (nz_fwd_data)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard model ----------------
    function automatic logic [EW-1:0] make_exp(input logic wr, input logic m2,
                                               input logic [DW-1:0] alu,
                                               input logic [DW-1:0] mo,
                                               input logic [RW-1:0] rn);
        wb_entry_t e;
        e.wreg  = wr && (rn != '0);
        e.m2reg = m2;
        e.alu   = alu;
        e.mo    = mo;
        e.wdata = m2 ? mo : alu;
        e.rn    = rn;
        return e;
    endfunction

    always @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            exp_q.delete();
            m_rdy = 1'b1;
        end else begin
            bit acc;
            bit pp;
            acc = in_valid && m_rdy && !flush;
            pp  = (exp_q.size() > 0) && out_ready;
            if (pp) void'(exp_q.pop_front());
            if (flush) exp_q.delete();
            else if (acc) exp_q.push_back(make_exp(in_wreg, in_m2reg, in_alu, in_mo, in_rn));
            m_rdy = (exp_q.size() < 2);
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            n_cmp++;
            if (in_ready !== m_rdy) begin
                n_err++;
                $display("FAIL mon_in_ready @%0t: got %b want %b", $time, in_ready, m_rdy);
            end
            n_cmp++;
            if (out_valid !== (exp_q.size() > 0)) begin
                n_err++;
                $display("FAIL mon_out_valid @%0t: got %b want %b", $time, out_valid, exp_q.size() > 0);
            end
            if (exp_q.size() > 0) begin
                n_cmp++;
                if ({out_wreg, out_m2reg, out_alu, out_mo, out_wdata, out_rn} !== exp_q[0]) begin
                    n_err++;
                    $display("FAIL mon_entry @%0t: got %h want %h", $time,
                             {out_wreg, out_m2reg, out_alu, out_mo, out_wdata, out_rn}, exp_q[0]);
                end
            end else begin
                n_cmp++;
                if (out_wreg !== 1'b0) begin
                    n_err++;
                    $display("FAIL mon_bubble_wreg @%0t: got %b want 0", $time, out_wreg);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push(input logic wr, input logic m2, input logic [DW-1:0] alu,
                        input logic [DW-1:0] mo, input logic [RW-1:0] rn);
        in_valid = 1'b1;
        in_wreg  = wr;
        in_m2reg = m2;
        in_alu   = alu;
        in_mo    = mo;
        in_rn    = rn;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_wreg  = 1'b1;
        in_m2reg = 1'($urandom_range(0, 1));
        in_alu   = $urandom;
        in_mo    = $urandom;
        in_rn    = RW'($urandom_range(0, 31));
    endtask

    task automatic drain();
        idle();
        out_ready = 1'b1;
        flush     = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        clrn = 1'b1;
        #2 clrn = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_wreg !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: in_ready=%b out_valid=%b out_wreg=%b want 1 0 0",
                     in_ready, out_valid, out_wreg);
        end
        n_cmp++;
        if ({out_m2reg, out_alu, out_mo, out_wdata, out_rn} !== '0) begin
            n_err++;
            $display("FAIL reset_data: got m2reg=%b alu=%h mo=%h wdata=%h rn=%0d want all 0",
                     out_m2reg, out_alu, out_mo, out_wdata, out_rn);
        end
        n_cmp++;
        if (dbg_state !== ST_EMPTY) begin
            n_err++;
            $display("FAIL reset_state: got %b want %b", dbg_state, ST_EMPTY);
        end
        clrn   = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        push(1'b1, 1'b1, 32'h11, 32'h22, 5'd5);
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1 || out_wdata !== 32'h22 || out_wreg !== 1'b1 || out_rn !== 5'd5) begin
            n_err++;
            $display("FAIL stream_first: valid=%b wdata=%h wreg=%b rn=%0d want 1 22 1 5",
                     out_valid, out_wdata, out_wreg, out_rn);
        end
        for (int i = 0; i < 6; i++) begin
            push(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
                 RW'($urandom_range(0, 31)));
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b1 || in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL stream_b2b[%0d]: valid=%b in_ready=%b want 1 1", i, out_valid, in_ready);
            end
        end
        drain();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        push(1'b1, 1'b0, 32'h1, 32'hA1, 5'd3);
        @(negedge clk);
        push(1'b1, 1'b0, 32'h2, 32'hA2, 5'd4);
        @(negedge clk);
        idle();
        n_cmp++;
        if (in_ready !== 1'b0 || out_alu !== 32'h1 || dbg_state !== ST_FULL) begin
            n_err++;
            $display("FAIL bp_full: in_ready=%b alu=%h state=%b want 0 1 %b",
                     in_ready, out_alu, dbg_state, ST_FULL);
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (out_alu !== 32'h1 || out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL bp_hold: alu=%h valid=%b want 1 1", out_alu, out_valid);
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (out_alu !== 32'h2 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_second: alu=%h in_ready=%b want 2 1", out_alu, in_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_drained: valid=%b want 0", out_valid);
        end
        drain();
    endtask

    task automatic test_zero_reg();
        out_ready = 1'b1;
        push(1'b1, 1'b0, 32'h33, 32'h44, 5'd0);
        @(negedge clk);
        idle();
        n_cmp++;
        if (out_valid !== 1'b1 || out_wreg !== 1'b0) begin
            n_err++;
            $display("FAIL zero_skip1: valid=%b wreg=%b want 1 0", out_valid, out_wreg);
        end
        n_cmp++;
        if (nz_out_valid !== 1'b1 || nz_out_wreg !== 1'b1) begin
            n_err++;
            $display("FAIL zero_skip0: valid=%b wreg=%b want 1 1", nz_out_valid, nz_out_wreg);
        end
        drain();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        push(1'b1, 1'b0, 32'h51, 32'h0, 5'd6);
        @(negedge clk);
        push(1'b1, 1'b0, 32'h52, 32'h0, 5'd7);
        @(negedge clk);
        flush = 1'b1;
        push(1'b1, 1'b0, 32'hBAD, 32'hBAD, 5'd9);
        @(negedge clk);
        flush = 1'b0;
        idle();
        n_cmp++;
        if (out_valid !== 1'b0 || out_wreg !== 1'b0 || in_ready !== 1'b1 || dbg_state !== ST_EMPTY) begin
            n_err++;
            $display("FAIL flush_full: valid=%b wreg=%b in_ready=%b state=%b want 0 0 1 %b",
                     out_valid, out_wreg, in_ready, dbg_state, ST_EMPTY);
        end
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL flush_no_ghost: valid=%b want 0", out_valid);
        end
        // Flush together with a pop: WB still sees the current entry.
        out_ready = 1'b0;
        push(1'b1, 1'b1, 32'h0, 32'h61, 5'd8);
        @(negedge clk);
        out_ready = 1'b1;
        flush     = 1'b1;
        push(1'b1, 1'b0, 32'h62, 32'h0, 5'd9);
        n_cmp++;
        if (out_valid !== 1'b1 || out_wdata !== 32'h61) begin
            n_err++;
            $display("FAIL flush_pop_seen: valid=%b wdata=%h want 1 61", out_valid, out_wdata);
        end
        @(negedge clk);
        flush = 1'b0;
        idle();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL flush_pop_empty: valid=%b want 0", out_valid);
        end
        drain();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        push(1'b1, 1'b0, 32'h71, 32'h0, 5'd10);
        @(negedge clk);
        push(1'b1, 1'b1, 32'h0, 32'h72, 5'd11);
        @(negedge clk);
        idle();
        @(posedge clk);
        #2;
        n_cmp++;
        if (dbg_state !== ST_FULL) begin
            n_err++;
            $display("FAIL areset_pre: state=%b want %b", dbg_state, ST_FULL);
        end
        clrn = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || out_wreg !== 1'b0 || in_ready !== 1'b1 ||
            {out_m2reg, out_alu, out_mo, out_wdata, out_rn} !== '0) begin
            n_err++;
            $display("FAIL areset_now: valid=%b wreg=%b in_ready=%b alu=%h wdata=%h rn=%0d want 0 0 1 0 0 0",
                     out_valid, out_wreg, in_ready, out_alu, out_wdata, out_rn);
        end
        @(negedge clk);
        // First accept lands on the first edge after release.
        clrn      = 1'b1;
        out_ready = 1'b1;
        push(1'b1, 1'b0, 32'h81, 32'h0, 5'd12);
        @(negedge clk);
        idle();
        n_cmp++;
        if (out_valid !== 1'b1 || out_alu !== 32'h81) begin
            n_err++;
            $display("FAIL areset_first: valid=%b alu=%h want 1 81", out_valid, out_alu);
        end
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) != 0)
                push(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
                     RW'($urandom_range(0, 31)));
            else
                idle();
            out_ready = 1'($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            @(negedge clk);
        end
        drain();
    endtask

`ifdef MEMWB_FWD_EN
    task automatic test_fwd();
        out_ready = 1'b0;
        push(1'b1, 1'b0, 32'hDEAD, 32'h0, 5'd7);
        @(negedge clk);
        idle();
        n_cmp++;
        if (fwd_hit !== 1'b1 || fwd_rn !== 5'd7 || fwd_data !== 32'hDEAD) begin
            n_err++;
            $display("FAIL fwd_hit: hit=%b rn=%0d data=%h want 1 7 dead", fwd_hit, fwd_rn, fwd_data);
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (fwd_hit !== 1'b0) begin
            n_err++;
            $display("FAIL fwd_idle: hit=%b want 0", fwd_hit);
        end
        drain();
    endtask
`endif

    // ---------------- sequence + report ----------------
    initial begin
        clrn      = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        idle();
        test_reset();
        test_stream();
        test_backpressure();
        test_zero_reg();
        test_flush();
        test_async_reset();
`ifdef MEMWB_FWD_EN
        test_fwd();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
